qpsk_stream_modulator: RTL and testbench
========================================

Name: qpsk_stream_modulator

Overview:
Streaming, parametrised QPSK modulator. Accepts DATA_W-bit words over a valid/ready handshake. Serialises each word MSB-first into ceil(DATA_W/2) QPSK symbols, one symbol per accepted output beat, with signed SYM_W-bit I/Q amplitudes. Sits between the framing/encoding stage and the channel/DAC path, and replaces the fixed 7-bit, 4-symbol combinational mapper.

Parameters:
DATA_W, 7, input word width in bits (>=2).
SYM_W, 16, signed width of each I and Q output sample.
AMP, 23170, symbol magnitude, two's complement; default is 0.7071 in Q1.15. Must satisfy 0 < AMP < 2^(SYM_W-1).
NSYM, (DATA_W+1)/2, symbols per word; derived, not to be overridden.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_data  in  DATA_W  word to modulate
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word this cycle
sym_i  out  SYM_W  signed in-phase sample
sym_q  out  SYM_W  signed quadrature sample
sym_valid  out  1  sym_i/sym_q/sym_idx/sym_last valid
sym_ready  in  1  downstream accepts symbol
sym_idx  out  clog2(NSYM) (min 1)  symbol index within word, 0 = first
sym_last  out  1  high on final symbol of word (sym_idx == NSYM-1)

Behaviour:
- Reset (async assert, sync release): state=IDLE; sym_i=0, sym_q=0, sym_valid=0, sym_idx=0, sym_last=0; in_ready=1 after release. Any word in flight is discarded, and no partial word resumes.
- Padding: odd DATA_W appends one 0 bit at the LSB, giving a 2*NSYM-bit frame.
- Pair order: frame split MSB-first into pairs (b1,b0).
- Mapping:
  - b1 selects I: 0 -> +AMP, 1 -> -AMP.
  - b0 selects Q: 0 -> +AMP, 1 -> -AMP.
  - This is a Gray-coded constellation, so adjacent points differ in one bit.
- Accept: a word is accepted on a cycle where in_valid && in_ready.
- FSM IDLE:
  - in_ready=1, sym_valid=0.
  - On accept: load shift register with the frame, drive symbol 0 registered on the next edge (sym_valid=1, sym_idx=0), go to SEND.
  - Latency from accept edge to first sym_valid is exactly 1 clock.
- FSM SEND, sym_valid=1:
  - Stall: if !sym_ready, all sym_* outputs hold stable, with no change to data or index.
  - Advance: on sym_valid && sym_ready with sym_idx < NSYM-1, shift 2 bits and present the next symbol the following cycle; sym_idx increments.
  - Last beat: on sym_valid && sym_ready with sym_last=1, the word is complete.
    - If in_valid is also high, the new word is accepted on the same edge (in_ready=1 combinationally in this case) and its symbol 0 appears next cycle with no bubble.
    - Otherwise go to IDLE, sym_valid=0, and sym_i/sym_q return to 0.
- in_ready = (state==IDLE) || (sym_valid && sym_ready && sym_last). It is never high while a non-final symbol is pending.
- in_data is sampled only on the accept edge; later changes are ignored.
- NSYM==1 (DATA_W=2): every symbol has sym_last=1 and sym_idx=0; back-to-back gives 1 word per cycle.
- Throughput with sym_ready held high: one symbol per clock, NSYM clocks per word, no gaps between words.
- Outputs are all registered, except in_ready, which is the only combinational output.

Test Plan:
1. Reset, then in_data=7'b1100110, sym_ready=1 -> frame 11001100. Four beats (I,Q) = (A57E,A57E), (5A82,5A82), (A57E,A57E), (5A82,5A82). sym_idx 0..3, sym_last only on beat 3, first sym_valid 1 clk after accept.
2. Back-to-back 7'b1010011 then 7'b0110001, in_valid held, sym_ready=1.
   - Word 1 (10,10,01,10): (A57E,5A82), (A57E,5A82), (5A82,A57E), (A57E,5A82).
   - Word 2 (01,10,00,10): (5A82,A57E), (A57E,5A82), (5A82,5A82), (A57E,5A82).
   - No bubble; in_ready high only on the last-beat cycle.
3. Backpressure: word 7'b0001110, sym_ready low 3 cycles on beat 1 -> sym_i=5A82, sym_q=A57E, sym_idx=1 held stable; in_ready=0 throughout; sequence resumes intact.
4. Reset asserted mid-word at beat 2 -> outputs 0 and sym_valid=0 immediately (async). After release, in_ready=1; the next word starts at sym_idx=0.
5. Parameter sweep DATA_W=2 with AMP=16384: in_data 2'b01 then 2'b10 back-to-back -> (4000,C000), (C000,4000) on consecutive clocks, sym_last=1 on both.
6. in_data changed while in SEND -> emitted symbols match the word captured at accept.

Source files
------------

// File: rtl/qpsk_stream_modulator.sv
// Streaming QPSK modulator: serialises DATA_W-bit words MSB-first into Gray-mapped
// I/Q symbols over valid/ready handshakes on both sides.
module qpsk_stream_modulator #(
    parameter int DATA_W = 7,
    parameter int SYM_W  = 16,
    parameter int AMP    = 23170,
    parameter int NSYM   = (DATA_W + 1) / 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [DATA_W-1:0]                       in_data,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [SYM_W-1:0]                        sym_i,
    output logic [SYM_W-1:0]                        sym_q,
    output logic                                    sym_valid,
    input  logic                                    sym_ready,
    output logic [((NSYM > 1) ? $clog2(NSYM) : 1)-1:0] sym_idx,
    output logic                                    sym_last
);

    localparam int FW    = 2 * NSYM;
    localparam int PAD   = FW - DATA_W;
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    localparam logic signed [SYM_W-1:0] POS = SYM_W'(AMP);
    localparam logic signed [SYM_W-1:0] NEG = -POS;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                   state_q, state_d;
    logic [FW-1:0]            shreg_q, shreg_d;
    logic signed [SYM_W-1:0]  i_q, i_d, q_q, q_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     last_q, last_d;

    logic                     fire, done, accept;
    logic [FW-1:0]            frame;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            i_q     <= '0;
            q_q     <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            i_q     <= i_d;
            q_q     <= q_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (done && !in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; in_ready reopens combinationally on the final beat
    always_comb begin
        fire     = (state_q == SEND) && sym_ready;
        done     = fire && last_q;
        in_ready = (state_q == IDLE) || done;
        accept   = in_valid && in_ready;
    end

    // Datapath next-state: load frame, advance a symbol, or return to zero
    always_comb begin
        shreg_d = shreg_q;
        i_d     = i_q;
        q_d     = q_q;
        idx_d   = idx_q;
        last_d  = last_q;
        frame   = FW'(in_data) << PAD;
        if (accept) begin
            i_d     = frame[FW-1] ? NEG : POS;
            q_d     = frame[FW-2] ? NEG : POS;
            shreg_d = frame << 2;
            idx_d   = '0;
            last_d  = (NSYM == 1);
        end else if (done) begin
            i_d    = '0;
            q_d    = '0;
            idx_d  = '0;
            last_d = 1'b0;
        end else if (fire) begin
            i_d     = shreg_q[FW-1] ? NEG : POS;
            q_d     = shreg_q[FW-2] ? NEG : POS;
            shreg_d = shreg_q << 2;
            idx_d   = idx_q + 1'b1;
            last_d  = (idx_q == IDX_W'(NSYM - 2));
        end
    end

    assign sym_valid = (state_q == SEND);
    assign sym_i     = i_q;
    assign sym_q     = q_q;
    assign sym_idx   = idx_q;
    assign sym_last  = last_q;

endmodule

// File: tb/tb_qpsk_stream_modulator.sv
// Scoreboard bench for qpsk_stream_modulator: default 7-bit instance plus a
// DATA_W=2, AMP=16384 instance, both checked against an arithmetic reference.
module tb_qpsk_stream_modulator;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        int          idx;
        bit          last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;

    logic [6:0]  in_data;
    logic        in_valid, in_ready;
    logic [15:0] sym_i, sym_q;
    logic        sym_valid, sym_ready, sym_last;
    logic [1:0]  sym_idx;

    logic [1:0]  in2_data;
    logic        in2_valid, in2_ready;
    logic [15:0] sym2_i, sym2_q;
    logic        sym2_valid, sym2_ready, sym2_last;
    logic [0:0]  sym2_idx;

    int nvec = 0;
    int nerr = 0;
    bit rdy_rand = 1'b0;
    bit rdy_force = 1'b1;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    qpsk_stream_modulator dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sym_i(sym_i), .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_idx(sym_idx), .sym_last(sym_last)
    );

    qpsk_stream_modulator #(.DATA_W(2), .SYM_W(16), .AMP(16384)) dut2 (
        .clk(clk), .rst(rst), .in_data(in2_data), .in_valid(in2_valid), .in_ready(in2_ready),
        .sym_i(sym2_i), .sym_q(sym2_q), .sym_valid(sym2_valid), .sym_ready(sym2_ready),
        .sym_idx(sym2_idx), .sym_last(sym2_last)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pad word to 2*nsym bits, take pair k from the MSB end, map each bit
    function automatic logic [31:0] model(input int dw, input int amp, input int w, input int k);
        int nsym, frame, pair;
        logic [15:0] pos, neg;
        nsym  = (dw + 1) / 2;
        frame = w * (1 << (2 * nsym - dw));
        pair  = (frame >> (2 * (nsym - 1 - k))) % 4;
        pos   = 16'(amp);
        neg   = 16'(-amp);
        return {(pair >= 2) ? neg : pos, (pair % 2 == 1) ? neg : pos};
    endfunction

    // Ready generator
    always begin
        @(posedge clk);
        #2;
        sym_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    // Monitor / scoreboard for the 7-bit instance
    bit          acc1 = 0, stall1 = 0;
    logic [35:0] snap1;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] m;
        if (rst) begin
            q1.delete();
            acc1   = 0;
            stall1 = 0;
        end else begin
            if (acc1) chk("latency", sym_valid, 1);
            if (stall1) chk("stall_hold", {sym_valid, sym_last, sym_idx, sym_i, sym_q}, snap1);
            if (sym_valid) begin
                if (!(sym_ready && sym_last)) chk("in_ready_low", in_ready, 0);
            end else begin
                chk("idle_iq", {sym_i, sym_q}, 0);
                chk("idle_ready", in_ready, 1);
            end
            if (sym_valid && sym_ready) begin
                if (q1.size() == 0) chk("unexpected_sym", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sym_i", sym_i, e.i);
                    chk("sym_q", sym_q, e.q);
                    chk("sym_idx", sym_idx, e.idx);
                    chk("sym_last", sym_last, e.last);
                end
            end
            stall1 = sym_valid && !sym_ready;
            snap1  = {sym_valid, sym_last, sym_idx, sym_i, sym_q};
            acc1   = in_valid && in_ready;
            if (acc1) begin
                for (int k = 0; k < 4; k++) begin
                    m      = model(7, 23170, int'(in_data), k);
                    e.i    = m[31:16];
                    e.q    = m[15:0];
                    e.idx  = k;
                    e.last = (k == 3);
                    q1.push_back(e);
                end
            end
        end
    end

    // Monitor / scoreboard for the DATA_W=2 instance
    bit acc2 = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] m;
        if (rst) begin
            q2.delete();
            acc2 = 0;
        end else begin
            if (acc2) chk("latency2", sym2_valid, 1);
            if (!sym2_valid) chk("idle2_iq", {sym2_i, sym2_q}, 0);
            if (sym2_valid && sym2_ready) begin
                if (q2.size() == 0) chk("unexpected_sym2", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("sym2_i", sym2_i, e.i);
                    chk("sym2_q", sym2_q, e.q);
                    chk("sym2_idx", sym2_idx, e.idx);
                    chk("sym2_last", sym2_last, e.last);
                end
            end
            acc2 = in2_valid && in2_ready;
            if (acc2) begin
                m      = model(2, 16384, int'(in2_data), 0);
                e.i    = m[31:16];
                e.q    = m[15:0];
                e.idx  = 0;
                e.last = 1;
                q2.push_back(e);
            end
        end
    end

    // Offer a word; return at posedge+1 after the accepting edge, scrambling in_data
    task automatic put(input logic [6:0] w);
        bit ok = 0;
        in_data  = w;
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 7'($urandom);
        chk("put_timeout", ok, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        sym_ready = 1'b1;
        in2_data  = '0;
        in2_valid = 1'b0;
        sym2_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", sym_valid, 0);
        chk("rst_iq", {sym_i, sym_q}, 0);
        chk("rst_idx_last", {sym_idx, sym_last}, 0);
        chk("rst_in_ready", in_ready, 1);
        idle_cycles(1);

        put(7'b1100110);
        idle_cycles(6);

        put(7'b1010011);
        put(7'b0110001);
        idle_cycles(6);

        // Stall on beat 1
        put(7'b0001110);
        @(negedge clk);
        rdy_force = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_i", sym_i, 16'h5A82);
            chk("stall_q", sym_q, 16'hA57E);
            chk("stall_idx", sym_idx, 1);
            chk("stall_ready", in_ready, 0);
        end
        rdy_force = 1'b1;
        idle_cycles(6);

        // Asynchronous reset at beat 2
        put(7'($urandom));
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sym_valid && sym_idx == 2) begin
                seen = 1;
                break;
            end
        end
        chk("reach_beat2", seen, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", sym_valid, 0);
        chk("arst_iq", {sym_i, sym_q}, 0);
        chk("arst_idx_last", {sym_idx, sym_last}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_ready", in_ready, 1);
        idle_cycles(1);
        put(7'b0101101);
        idle_cycles(6);

        // Randomised traffic with random backpressure
        rdy_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
            put(7'($urandom));
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (q1.size() == 0 && !sym_valid) begin
                seen = 1;
                break;
            end
        end
        chk("drain1", seen, 1);

        // DATA_W=2: 01 then 10 back-to-back, then a random burst
        idle_cycles(1);
        in2_data  = 2'b01;
        in2_valid = 1'b1;
        @(posedge clk);
        #1 in2_data = 2'b10;
        @(posedge clk);
        for (int n = 0; n < 12; n++) begin
            #1 in2_data = 2'($urandom);
            @(posedge clk);
        end
        #1 in2_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (q2.size() == 0 && !sym2_valid) begin
                seen = 1;
                break;
            end
        end
        chk("drain2", seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
